// File: rtl/mem_ptr_access_ctrl_pkg.sv
// mem_ctrl_pkg: shared encodings for the memory-stage pointer access controller.
//   - pointer select codes (also the address-mux select encoding)
//   - access mode codes
//   - controller FSM state enum
package mem_ctrl_pkg;

    localparam logic [1:0] SEL_SP = 2'b00;
    localparam logic [1:0] SEL_X  = 2'b01;
    localparam logic [1:0] SEL_Y  = 2'b10;
    localparam logic [1:0] SEL_Z  = 2'b11;

    // Code 2'b11 is reserved and handled exactly like MODE_NONE.
    localparam logic [1:0] MODE_NONE    = 2'b00;
    localparam logic [1:0] MODE_POSTINC = 2'b01;
    localparam logic [1:0] MODE_PREDEC  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PREDEC = 2'd1,
        ST_REQ    = 2'd2
    } state_e;

    // True only for the exact post-increment code; the reserved code falls through to "none".
    function automatic logic is_postinc(input logic [1:0] mode);
        return (mode == MODE_POSTINC);
    endfunction

    // True only for the exact pre-decrement code.
    function automatic logic is_predec(input logic [1:0] mode);
        return (mode == MODE_PREDEC);
    endfunction

endpackage

// File: rtl/mem_ptr_access_ctrl_if.sv
// mem_ptr_access_ctrl_if: bundles the pipeline op handshake, external pointer load,
// address-mux outputs and the data-memory port of mem_ptr_access_ctrl.
//   modport slave  : the controller
//   modport master : the surrounding pipeline / memory environment
interface mem_ptr_access_ctrl_if #(
    parameter int PTR_W  = 16,
    parameter int DATA_W = 8
);
    // pipeline op handshake
    logic              op_valid;
    logic              op_ready;
    logic [1:0]        op_sel;
    logic [1:0]        op_mode;
    logic              op_we;
    logic [DATA_W-1:0] op_wdata;
    // external pointer load
    logic              ptr_wr_en;
    logic [1:0]        ptr_wr_sel;
    logic [PTR_W-1:0]  ptr_wr_data;
    // address-mux side
    logic [1:0]        sel_signals;
    logic [PTR_W-1:0]  x_ptr;
    logic [PTR_W-1:0]  y_ptr;
    logic [PTR_W-1:0]  z_ptr;
    logic [PTR_W-1:0]  stack_ptr;
    // data-memory port
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    // completion
    logic [DATA_W-1:0] rd_data;
    logic              done;

    modport slave (
        input  op_valid, op_sel, op_mode, op_we, op_wdata,
        input  ptr_wr_en, ptr_wr_sel, ptr_wr_data,
        input  mem_ack, mem_rdata,
        output op_ready, sel_signals, x_ptr, y_ptr, z_ptr, stack_ptr,
        output mem_req, mem_we, mem_wdata, rd_data, done
    );

    modport master (
        output op_valid, op_sel, op_mode, op_we, op_wdata,
        output ptr_wr_en, ptr_wr_sel, ptr_wr_data,
        output mem_ack, mem_rdata,
        input  op_ready, sel_signals, x_ptr, y_ptr, z_ptr, stack_ptr,
        input  mem_req, mem_we, mem_wdata, rd_data, done
    );

endinterface

// File: rtl/mem_ptr_access_ctrl_ptr_regfile.sv
// ptr_regfile: the four pointer registers (SP, X, Y, Z).
//   clock, reset       : rising-edge clock, asynchronous active-high reset
//   upd_en/sel/dec     : one +1 / -1 update port (dec=1 decrements), wraps modulo 2^PTR_W
//   ld_en/sel/data     : external load port; beats an update aimed at the same register
//   x/y/z_ptr,stack_ptr: register values (direct flop outputs)
module ptr_regfile
    import mem_ctrl_pkg::*;
#(
    parameter int               PTR_W   = 16,
    parameter logic [PTR_W-1:0] SP_INIT = 16'hFFFF,
    parameter logic [PTR_W-1:0] X_INIT  = '0,
    parameter logic [PTR_W-1:0] Y_INIT  = '0,
    parameter logic [PTR_W-1:0] Z_INIT  = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             upd_en,
    input  logic [1:0]       upd_sel,
    input  logic             upd_dec,
    input  logic             ld_en,
    input  logic [1:0]       ld_sel,
    input  logic [PTR_W-1:0] ld_data,
    output logic [PTR_W-1:0] x_ptr,
    output logic [PTR_W-1:0] y_ptr,
    output logic [PTR_W-1:0] z_ptr,
    output logic [PTR_W-1:0] stack_ptr
);

    localparam logic [PTR_W-1:0] ONE = {{(PTR_W-1){1'b0}}, 1'b1};

    logic [PTR_W-1:0] ptr_r [4];

    // Pointer storage: external load has priority over the inc/dec update.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_r[SEL_SP] <= SP_INIT;
            ptr_r[SEL_X]  <= X_INIT;
            ptr_r[SEL_Y]  <= Y_INIT;
            ptr_r[SEL_Z]  <= Z_INIT;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (ld_en && (ld_sel == 2'(i))) begin
                    ptr_r[i] <= ld_data;
                end else if (upd_en && (upd_sel == 2'(i))) begin
                    ptr_r[i] <= upd_dec ? (ptr_r[i] - ONE) : (ptr_r[i] + ONE);
                end
            end
        end
    end

    assign stack_ptr = ptr_r[SEL_SP];
    assign x_ptr     = ptr_r[SEL_X];
    assign y_ptr     = ptr_r[SEL_Y];
    assign z_ptr     = ptr_r[SEL_Z];

endmodule

// File: rtl/mem_ptr_access_ctrl.sv
// mem_ptr_access_ctrl: memory-stage access controller. Accepts one pipeline access
// at a time, optionally pre-decrements the selected pointer, holds a memory request
// until acknowledged, captures read data, optionally post-increments, then pulses done.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   bus (slave)  : op handshake, external pointer load, mux select/pointers, memory port
module mem_ptr_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter logic [15:0] SP_INIT = 16'hFFFF,
    parameter int          PTR_W   = 16,
    parameter int          DATA_W  = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    mem_ptr_access_ctrl_if.slave  bus
);

    state_e            state_r;
    state_e            state_next_s;
    logic              accept_s;
    logic              ack_s;
    logic              upd_en_s;
    logic              upd_dec_s;
    logic              we_next_s;

    logic [1:0]        sel_r;
    logic [1:0]        mode_r;
    logic              we_r;
    logic [DATA_W-1:0] wdata_r;
    logic              op_ready_r;
    logic              mem_req_r;
    logic              mem_we_r;
    logic [DATA_W-1:0] rd_data_r;
    logic              done_r;

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and pointer-update decode.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        ack_s        = 1'b0;
        upd_en_s     = 1'b0;
        upd_dec_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // op_ready_r also masks the done cycle, which is spent in IDLE.
                if (bus.op_valid && op_ready_r) begin
                    accept_s = 1'b1;
                    if (is_predec(bus.op_mode)) begin
                        state_next_s = ST_PREDEC;
                    end else begin
                        state_next_s = ST_REQ;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_PREDEC: begin
                upd_en_s     = 1'b1;
                upd_dec_s    = 1'b1;
                state_next_s = ST_REQ;
            end
            ST_REQ: begin
                if (bus.mem_ack) begin
                    ack_s        = 1'b1;
                    upd_en_s     = is_postinc(mode_r);
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    assign we_next_s = accept_s ? bus.op_we : we_r;

    // Op latches and registered outputs, all computed from the next state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sel_r      <= SEL_SP;
            mode_r     <= MODE_NONE;
            we_r       <= 1'b0;
            wdata_r    <= '0;
            op_ready_r <= 1'b1;
            mem_req_r  <= 1'b0;
            mem_we_r   <= 1'b0;
            rd_data_r  <= '0;
            done_r     <= 1'b0;
        end else begin
            if (accept_s) begin
                sel_r   <= bus.op_sel;
                mode_r  <= bus.op_mode;
                we_r    <= bus.op_we;
                wdata_r <= bus.op_wdata;
            end
            if (ack_s && !we_r) begin
                rd_data_r <= bus.mem_rdata;
            end
            op_ready_r <= (state_next_s == ST_IDLE) && !ack_s;
            mem_req_r  <= (state_next_s == ST_REQ);
            mem_we_r   <= (state_next_s == ST_REQ) && we_next_s;
            done_r     <= ack_s;
        end
    end

    ptr_regfile #(
        .PTR_W   (PTR_W),
        .SP_INIT (SP_INIT[PTR_W-1:0]),
        .X_INIT  ({PTR_W{1'b0}}),
        .Y_INIT  ({PTR_W{1'b0}}),
        .Z_INIT  ({PTR_W{1'b0}})
    ) u_ptr_regfile (
        .clock     (clock),
        .reset     (reset),
        .upd_en    (upd_en_s),
        .upd_sel   (sel_r),
        .upd_dec   (upd_dec_s),
        .ld_en     (bus.ptr_wr_en),
        .ld_sel    (bus.ptr_wr_sel),
        .ld_data   (bus.ptr_wr_data),
        .x_ptr     (bus.x_ptr),
        .y_ptr     (bus.y_ptr),
        .z_ptr     (bus.z_ptr),
        .stack_ptr (bus.stack_ptr)
    );

    assign bus.op_ready    = op_ready_r;
    assign bus.sel_signals = sel_r;
    assign bus.mem_req     = mem_req_r;
    assign bus.mem_we      = mem_we_r;
    assign bus.mem_wdata   = wdata_r;
    assign bus.rd_data     = rd_data_r;
    assign bus.done        = done_r;

endmodule

// File: tb/tb_mem_ptr_access_ctrl.sv
// Self-checking bench for mem_ptr_access_ctrl: directed scenarios followed by
// randomized accesses, checked against a pointer/read-data model kept here.
module tb_mem_ptr_access_ctrl;

    logic clock;
    logic reset;

    mem_ptr_access_ctrl_if #(.PTR_W(16), .DATA_W(8)) bus ();

    mem_ptr_access_ctrl #(
        .SP_INIT (16'hFFFF),
        .PTR_W   (16),
        .DATA_W  (8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: pointer values indexed by select code, last captured read data.
    logic [15:0] model_ptr [4];
    logic [7:0]  model_rd;
    int          n_pass;
    int          n_checks;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] ptr_of(input logic [1:0] s);
        case (s)
            2'b00:   return bus.stack_ptr;
            2'b01:   return bus.x_ptr;
            2'b10:   return bus.y_ptr;
            default: return bus.z_ptr;
        endcase
    endfunction

    task automatic model_reset();
        model_ptr[0] = 16'hFFFF;
        model_ptr[1] = 16'h0000;
        model_ptr[2] = 16'h0000;
        model_ptr[3] = 16'h0000;
        model_rd     = 8'h00;
    endtask

    task automatic check_all_ptrs(input string tag);
        check({tag, "_sp"}, bus.stack_ptr, model_ptr[0]);
        check({tag, "_x"},  bus.x_ptr,     model_ptr[1]);
        check({tag, "_y"},  bus.y_ptr,     model_ptr[2]);
        check({tag, "_z"},  bus.z_ptr,     model_ptr[3]);
    endtask

    // External load while idle; called and returns at a negedge.
    task automatic load_ptr(input logic [1:0] s, input logic [15:0] v);
        bus.ptr_wr_en   = 1'b1;
        bus.ptr_wr_sel  = s;
        bus.ptr_wr_data = v;
        @(negedge clock);
        bus.ptr_wr_en   = 1'b0;
        model_ptr[s]    = v;
        check("load", ptr_of(s), v);
    endtask

    // One complete access; called at a negedge with the controller idle and ready,
    // returns at the negedge of the cycle after done.
    task automatic do_op(input logic [1:0] s, input logic [1:0] mode, input logic we,
                         input logic [7:0] wd, input int waits, input logic [7:0] rdv,
                         input logic ld_on_ack, input logic [15:0] ld_val);
        logic [15:0] p;
        check("ready_idle", bus.op_ready, 1);
        bus.op_valid = 1'b1;
        bus.op_sel   = s;
        bus.op_mode  = mode;
        bus.op_we    = we;
        bus.op_wdata = wd;
        @(negedge clock);
        bus.op_valid = 1'b0;
        bus.op_sel   = 2'($urandom);
        bus.op_mode  = 2'($urandom);
        bus.op_wdata = 8'($urandom);
        p = model_ptr[s];
        if (mode == 2'b10) begin
            check("predec_noreq", bus.mem_req, 0);
            check("predec_busy", bus.op_ready, 0);
            p = p - 16'd1;
            model_ptr[s] = p;
            @(negedge clock);
        end
        for (int w = 0; w <= waits; w++) begin
            check("req", bus.mem_req, 1);
            check("sel", bus.sel_signals, s);
            check("mem_we", bus.mem_we, we);
            if (we) check("mem_wdata", bus.mem_wdata, wd);
            check("addr_ptr", ptr_of(s), p);
            check("busy", bus.op_ready, 0);
            check("no_early_done", bus.done, 0);
            if (w == waits) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = rdv;
                if (ld_on_ack) begin
                    bus.ptr_wr_en   = 1'b1;
                    bus.ptr_wr_sel  = s;
                    bus.ptr_wr_data = ld_val;
                end
            end else begin
                bus.mem_rdata = 8'($urandom);
            end
            @(negedge clock);
        end
        bus.mem_ack   = 1'b0;
        bus.ptr_wr_en = 1'b0;
        if (mode == 2'b01) p = p + 16'd1;
        if (ld_on_ack) p = ld_val;
        model_ptr[s] = p;
        if (!we) model_rd = rdv;
        check("done", bus.done, 1);
        check("req_dropped", bus.mem_req, 0);
        check("ready_in_done", bus.op_ready, 0);
        check("rd_data", bus.rd_data, model_rd);
        check("ptr_after", ptr_of(s), p);
        check("sel_hold", bus.sel_signals, s);
        @(negedge clock);
        check("done_one_cycle", bus.done, 0);
    endtask

    // Watchdog: the scenario is finite, this only guards against a hung simulator.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_pass          = 0;
        n_checks        = 0;
        reset           = 1'b1;
        bus.op_valid    = 1'b0;
        bus.op_sel      = 2'b00;
        bus.op_mode     = 2'b00;
        bus.op_we       = 1'b0;
        bus.op_wdata    = 8'h00;
        bus.ptr_wr_en   = 1'b0;
        bus.ptr_wr_sel  = 2'b00;
        bus.ptr_wr_data = 16'h0000;
        bus.mem_ack     = 1'b0;
        bus.mem_rdata   = 8'h00;
        model_reset();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Reset state
        check_all_ptrs("rst");
        check("rst_sel", bus.sel_signals, 0);
        check("rst_req", bus.mem_req, 0);
        check("rst_we", bus.mem_we, 0);
        check("rst_wdata", bus.mem_wdata, 0);
        check("rst_rd", bus.rd_data, 0);
        check("rst_done", bus.done, 0);
        check("rst_ready", bus.op_ready, 1);

        // X=1234, post-inc read, two wait cycles, A5
        load_ptr(2'b01, 16'h1234);
        do_op(2'b01, 2'b01, 1'b0, 8'h00, 2, 8'hA5, 1'b0, 16'h0000);
        check("x_1235", bus.x_ptr, 16'h1235);

        // Push 3C then pop
        do_op(2'b00, 2'b10, 1'b1, 8'h3C, 0, 8'h11, 1'b0, 16'h0000);
        check("sp_push", bus.stack_ptr, 16'hFFFE);
        do_op(2'b00, 2'b01, 1'b0, 8'h00, 1, 8'h3C, 1'b0, 16'h0000);
        check("sp_pop", bus.stack_ptr, 16'hFFFF);
        check("pop_data", bus.rd_data, 8'h3C);

        // Wrap cases
        load_ptr(2'b11, 16'hFFFF);
        do_op(2'b11, 2'b01, 1'b0, 8'h00, 0, 8'h5A, 1'b0, 16'h0000);
        check("z_wrap", bus.z_ptr, 16'h0000);
        do_op(2'b10, 2'b10, 1'b0, 8'h00, 0, 8'h77, 1'b0, 16'h0000);
        check("y_wrap", bus.y_ptr, 16'hFFFF);

        // Reserved mode behaves as none
        do_op(2'b01, 2'b11, 1'b1, 8'hC3, 1, 8'h00, 1'b0, 16'h0000);
        check("mode11_nochange", bus.x_ptr, 16'h1235);

        // External load collides with post-inc
        load_ptr(2'b01, 16'h0010);
        do_op(2'b01, 2'b01, 1'b0, 8'h00, 0, 8'h42, 1'b1, 16'h0050);
        check("collide_x", bus.x_ptr, 16'h0050);

        // Reset during REQ
        bus.op_valid = 1'b1;
        bus.op_sel   = 2'b10;
        bus.op_mode  = 2'b00;
        bus.op_we    = 1'b0;
        @(negedge clock);
        bus.op_valid = 1'b0;
        check("mid_req", bus.mem_req, 1);
        #1 reset = 1'b1;
        #1;
        check("async_req_drop", bus.mem_req, 0);
        check("async_ready", bus.op_ready, 1);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            check("no_done_after_rst", bus.done, 0);
            @(negedge clock);
        end
        check_all_ptrs("rst2");
        do_op(2'b10, 2'b01, 1'b0, 8'h00, 1, 8'h9E, 1'b0, 16'h0000);

        // Randomized accesses
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                load_ptr(2'($urandom), 16'($urandom));
            end
            do_op(2'($urandom), 2'($urandom), 1'($urandom), 8'($urandom),
                  int'($urandom_range(0, 3)), 8'($urandom),
                  ($urandom_range(0, 7) == 0), 16'($urandom));
        end
        check_all_ptrs("final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
